uart_baud_gen: RTL and testbench

//  Baud-rate generator and RX input conditioner feeding the async UART

---
 rtl/uart_baud_gen.sv | 110 +++++++++++
 tb/tb_uart_baud_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Baud-rate generator for the async UART: SPBRG register, /4 prescaler, 16x sample
// strobe, 1x shift strobe, and the RXD pin synchroniser.
module uart_baud_gen #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic       brgh,
  input  logic       spbrg_reg_wr_en,
  input  logic [7:0] spbrg_reg_in,
  output logic [7:0] spbrg_reg_out,
  output logic       uart_rx_async_div16_en,
  output logic       uart_tx_shift_en,
  input  logic       uart_rxd_pin,
  output logic       uart_rxd_sync
);

  logic [7:0]             spbrg_r;
  logic [1:0]             pre_cnt_r;
  logic [7:0]             brg_cnt_r;
  logic [3:0]             div_cnt_r;
  logic                   div16_r;
  logic                   tx_shift_r;
  logic                   brgh_r;
  logic                   brgh_seen_r;
  logic [SYNC_STAGES-1:0] rxd_sync_r;

  logic step_s;
  logic fire_s;
  logic brgh_tgl_s;

  // Prescaler step, terminal-count fire and BRGH edge detection
  always_comb begin
    step_s     = 1'b0;
    fire_s     = 1'b0;
    brgh_tgl_s = 1'b0;
    if (brgh) begin
      step_s = 1'b1;
    end else begin
      step_s = (pre_cnt_r == 2'd3);
    end
    fire_s = step_s && (brg_cnt_r == 8'd0);
    // brgh_r holds no meaningful history until the first edge after reset
    brgh_tgl_s = brgh_seen_r && (brgh != brgh_r);
  end

  // Baud counters and registered strobes; a write beats sync, sync beats a BRGH toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spbrg_r     <= 8'h00;
      pre_cnt_r   <= 2'd0;
      brg_cnt_r   <= 8'd0;
      div_cnt_r   <= 4'd0;
      div16_r     <= 1'b0;
      tx_shift_r  <= 1'b0;
      brgh_r      <= 1'b0;
      brgh_seen_r <= 1'b0;
    end else begin
      brgh_r      <= brgh;
      brgh_seen_r <= 1'b1;
      if (spbrg_reg_wr_en) begin
        spbrg_r    <= spbrg_reg_in;
        pre_cnt_r  <= 2'd0;
        brg_cnt_r  <= spbrg_reg_in;
        div_cnt_r  <= 4'd0;
        div16_r    <= 1'b0;
        tx_shift_r <= 1'b0;
      end else if (sync) begin
        pre_cnt_r  <= 2'd0;
        brg_cnt_r  <= spbrg_r;
        div_cnt_r  <= 4'd0;
        div16_r    <= 1'b0;
        tx_shift_r <= 1'b0;
      end else if (brgh_tgl_s) begin
        pre_cnt_r  <= 2'd0;
        brg_cnt_r  <= spbrg_r;
        div16_r    <= 1'b0;
        tx_shift_r <= 1'b0;
      end else begin
        pre_cnt_r  <= pre_cnt_r + 2'd1;
        if (fire_s) begin
          brg_cnt_r <= spbrg_r;
          div_cnt_r <= div_cnt_r + 4'd1;
        end else if (step_s) begin
          brg_cnt_r <= brg_cnt_r - 8'd1;
        end else begin
          brg_cnt_r <= brg_cnt_r;
        end
        div16_r    <= fire_s;
        tx_shift_r <= fire_s && (div_cnt_r == 4'd15);
      end
    end
  end

  // RXD synchroniser; idles high so a reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      rxd_sync_r <= {rxd_sync_r[SYNC_STAGES-2:0], uart_rxd_pin};
    end
  end

  assign spbrg_reg_out          = spbrg_r;
  assign uart_rx_async_div16_en = div16_r;
  assign uart_tx_shift_en       = tx_shift_r;
  assign uart_rxd_sync          = rxd_sync_r[SYNC_STAGES-1];

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: table of SPBRG/BRGH settings with hand-computed
// strobe periods, plus sequences for write collision, sync hold, BRGH toggle, RXD and reset.
module tb_uart_baud_gen;
  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       rst;
  logic       sync;
  logic       brgh;
  logic       spbrg_reg_wr_en;
  logic [7:0] spbrg_reg_in;
  logic [7:0] spbrg_reg_out;
  logic       div16;
  logic       tx_en;
  logic       uart_rxd_pin;
  logic       uart_rxd_sync;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0] x;
    logic       b;
    int         n_exp;
    int         tx_exp;
  } vec_t;

  vec_t vecs[8];

  uart_baud_gen #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .sync                   (sync),
    .brgh                   (brgh),
    .spbrg_reg_wr_en        (spbrg_reg_wr_en),
    .spbrg_reg_in           (spbrg_reg_in),
    .spbrg_reg_out          (spbrg_reg_out),
    .uart_rx_async_div16_en (div16),
    .uart_tx_shift_en       (tx_en),
    .uart_rxd_pin           (uart_rxd_pin),
    .uart_rxd_sync          (uart_rxd_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Write at edge E; the cycle after E must show no strobes and the new SPBRG
  task automatic do_write(input logic [7:0] x, input logic b);
    @(negedge clk);
    spbrg_reg_in    = x;
    brgh            = b;
    spbrg_reg_wr_en = 1'b1;
    @(posedge clk);
    #1;
    check("wr_div16_low", int'(div16), 0);
    check("wr_tx_low", int'(tx_en), 0);
    check("spbrg_out", int'(spbrg_reg_out), int'(x));
    @(negedge clk);
    spbrg_reg_wr_en = 1'b0;
  endtask

  // Counts edges after the reference edge: first div16, div16 period, first tx strobe
  task automatic measure(input string name, input int n_exp, input int tx_exp);
    int first;
    int second;
    int txk;
    int lim;
    first  = 0;
    second = 0;
    txk    = 0;
    lim    = tx_exp + 2 * n_exp + 8;
    for (int k = 1; k <= lim && (second == 0 || txk == 0); k++) begin
      @(posedge clk);
      #1;
      if (div16) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (tx_en && txk == 0) txk = k;
    end
    check({name, "_first_div16"}, first, n_exp);
    check({name, "_div16_period"}, second - first, n_exp);
    check({name, "_first_tx"}, txk, tx_exp);
  endtask

  initial begin
    int hits;
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{x: 8'h00, b: 1'b1, n_exp: 1,   tx_exp: 16};
    vecs[1] = '{x: 8'h00, b: 1'b0, n_exp: 4,   tx_exp: 64};
    vecs[2] = '{x: 8'h03, b: 1'b0, n_exp: 16,  tx_exp: 256};
    vecs[3] = '{x: 8'h05, b: 1'b0, n_exp: 24,  tx_exp: 384};
    vecs[4] = '{x: 8'h02, b: 1'b1, n_exp: 3,   tx_exp: 48};
    vecs[5] = '{x: 8'h02, b: 1'b0, n_exp: 12,  tx_exp: 192};
    vecs[6] = '{x: 8'hFF, b: 1'b1, n_exp: 256, tx_exp: 4096};
    vecs[7] = '{x: 8'h80, b: 1'b0, n_exp: 516, tx_exp: 8256};

    rst             = 1'b1;
    sync            = 1'b0;
    brgh            = 1'b1;
    spbrg_reg_wr_en = 1'b0;
    spbrg_reg_in    = 8'h00;
    uart_rxd_pin    = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_spbrg", int'(spbrg_reg_out), 0);
    check("rst_div16", int'(div16), 0);
    check("rst_tx", int'(tx_en), 0);
    check("rst_rxd", int'(uart_rxd_sync), 1);

    // X=0, brgh=1 after release: div16 every cycle, tx on cycles 16 and 32
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rel_div16_%0d", k), int'(div16), 1);
      check($sformatf("rel_tx_%0d", k), int'(tx_en), ((k % 16) == 0) ? 1 : 0);
    end

    // Table of settings, each applied by an SPBRG write
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].x, vecs[i].b);
      measure($sformatf("vec%0d", i), vecs[i].n_exp, vecs[i].tx_exp);
    end

    // Write coincident with terminal count: the write wins
    do_write(8'h03, 1'b0);
    hits = 0;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      if (div16) hits = hits + k;
    end
    check("pre_collide_fire_at_16", hits, 16);
    do_write(8'h05, 1'b0);
    measure("collide", 24, 384);

    // sync hold for 100 cycles, then release behaves like a write
    do_write(8'h03, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    sync = 1'b1;
    hits = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (div16 || tx_en) hits++;
    end
    check("sync_strobes", hits, 0);
    @(negedge clk);
    sync = 1'b0;
    measure("sync_rel", 16, 256);

    // BRGH 0->1 mid-count with X=2: period 12 becomes 3 from the toggle edge
    do_write(8'h02, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    brgh = 1'b1;
    @(posedge clk);
    #1;
    check("tgl_div16_low", int'(div16), 0);
    measure("tgl", 3, 48);

    // RXD falls SYNC_STAGES edges after the pin
    @(negedge clk);
    uart_rxd_pin = 1'b0;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rxd_edge_%0d", k), int'(uart_rxd_sync), (k == SYNC_STAGES) ? 0 : 1);
    end

    // Async reset mid-count clears everything without a clock edge
    do_write(8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_div16", int'(div16), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_div16", int'(div16), 0);
    check("async_rst_tx", int'(tx_en), 0);
    check("async_rst_rxd", int'(uart_rxd_sync), 1);
    check("async_rst_spbrg", int'(spbrg_reg_out), 0);
    brgh = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    measure("rst_resume", 4, 64);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
